// File: rtl/rotor_bank_if.sv
// Purpose: config, input and output channels of the rotor stack bundled for one port.
// Latency: n/a (wires only); timing is defined by rotor_bank.
// Backpressure: in_ready/out_ready carried here; master = surrounding datapath, slave = rotor_bank.
// Signals: cfg_* write port with cfg_err pulse; in_* character input; out_* character output;
//          step_vec/pos_out report the stepping of the last accepted character.
interface rotor_bank_if #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26
);
  localparam int W = $clog2(ALPHA);

  logic                    cfg_we;
  logic [1:0]              cfg_kind;
  logic [2:0]              cfg_sel;
  logic [W-1:0]            cfg_addr;
  logic [W-1:0]            cfg_data;
  logic                    cfg_err;

  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_char;

  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_char;
  logic                    out_err;
  logic [NUM_ROTORS-1:0]   step_vec;
  logic [NUM_ROTORS*W-1:0] pos_out;

  modport master (
    output cfg_we, cfg_kind, cfg_sel, cfg_addr, cfg_data,
    input  cfg_err,
    output in_valid, in_char,
    input  in_ready,
    input  out_valid, out_char, out_err, step_vec, pos_out,
    output out_ready
  );

  modport slave (
    input  cfg_we, cfg_kind, cfg_sel, cfg_addr, cfg_data,
    output cfg_err,
    input  in_valid, in_char,
    output in_ready,
    output out_valid, out_char, out_err, step_vec, pos_out,
    input  out_ready
  );
endinterface

// File: rtl/rotor_bank.sv
// Purpose: NUM_ROTORS rotors plus reflector with loadable wiring/ring/position/notch and double-step.
// Latency: 1 cycle from accept to out_valid; the full round trip is combinational in that cycle.
// Backpressure: in_ready = !cfg_we && (!out_valid || out_ready); output held while out_valid && !out_ready.
// Ports: clk, reset (sync, active-high); bus (rotor_bank_if.slave) carrying cfg_*, in_*, out_*,
//        step_vec (rotors stepped on last accept) and pos_out (positions, rotor 0 in the LSBs).
module rotor_bank #(
  parameter int NUM_ROTORS  = 3,
  parameter int ALPHA       = 26,
  parameter int DOUBLE_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  rotor_bank_if.slave  bus
);
  localparam int           W         = $clog2(ALPHA);
  localparam int           W1        = W + 1;
  localparam logic [W:0]   ALPHA_W1  = W1'(ALPHA);
  localparam logic [W-1:0] LAST      = W'(ALPHA - 1);
  localparam logic [W-1:0] NOTCH_RST = W'(16);
  localparam logic [3:0]   NR        = 4'(NUM_ROTORS);

  // Rotor tables and settings
  logic [W-1:0] fwd   [NUM_ROTORS][ALPHA];
  logic [W-1:0] bwd   [NUM_ROTORS][ALPHA];
  logic [W-1:0] refl  [ALPHA];
  logic [W-1:0] pos   [NUM_ROTORS];
  logic [W-1:0] ring  [NUM_ROTORS];
  logic [W-1:0] notch [NUM_ROTORS];

  // Output registers
  logic                  out_valid_q;
  logic [W-1:0]          out_char_q;
  logic                  out_err_q;
  logic [NUM_ROTORS-1:0] step_q;
  logic                  cfg_err_q;

  // Datapath
  logic                    in_ready;
  logic                    accept;
  logic                    in_range;
  logic                    cfg_bad;
  logic [NUM_ROTORS-1:0]   step;
  logic [W-1:0]            q [NUM_ROTORS];
  logic [W-1:0]            x;
  logic [W-1:0]            c;
  logic [W-1:0]            enc;
  logic [NUM_ROTORS*W-1:0] pos_flat;

  // Operands are always < ALPHA, so one conditional correction suffices.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ALPHA_W1) s = s - ALPHA_W1;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + ALPHA_W1;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] p);
    return (p == LAST) ? '0 : p + W'(1);
  endfunction

  assign in_ready = !bus.cfg_we && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign in_range = ({1'b0, bus.in_char} < ALPHA_W1);

  // Kind 0 may address index NUM_ROTORS (the reflector); other kinds only real rotors.
  always_comb begin
    cfg_bad = ({1'b0, bus.cfg_data} >= ALPHA_W1);
    if (bus.cfg_kind == 2'd0) begin
      if ({1'b0, bus.cfg_addr} >= ALPHA_W1) cfg_bad = 1'b1;
      if ({1'b0, bus.cfg_sel} > NR)         cfg_bad = 1'b1;
    end else if ({1'b0, bus.cfg_sel} >= NR) begin
      cfg_bad = 1'b1;
    end
  end

  // Stepping from pre-step positions. The double-step term lets a middle rotor
  // sitting on its own notch step again together with its left neighbour.
  always_comb begin
    step    = '0;
    step[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) begin
      step[i] = (pos[i-1] == notch[i-1]);
      if (DOUBLE_STEP != 0 && i < NUM_ROTORS - 1 && pos[i] == notch[i]) step[i] = 1'b1;
    end
    for (int i = 0; i < NUM_ROTORS; i++) begin
      q[i] = step[i] ? inc_mod(pos[i]) : pos[i];
    end
  end

  // Round trip with post-step positions. Out-of-range characters are bypassed at
  // the output, so feed 0 to keep every table index in range.
  always_comb begin
    x = in_range ? bus.in_char : '0;
    c = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      c = sub_mod(add_mod(x, q[i]), ring[i]);
      x = add_mod(sub_mod(fwd[i][c], q[i]), ring[i]);
    end
    x = refl[x];
    for (int i = NUM_ROTORS - 1; i >= 0; i--) begin
      c = sub_mod(add_mod(x, q[i]), ring[i]);
      x = add_mod(sub_mod(bwd[i][c], q[i]), ring[i]);
    end
    enc = x;
  end

  always_comb begin
    pos_flat = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      pos_flat[i*W +: W] = pos[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_err_q   <= 1'b0;
      step_q      <= '0;
      cfg_err_q   <= 1'b0;
      for (int r = 0; r < NUM_ROTORS; r++) begin
        pos[r]   <= '0;
        ring[r]  <= '0;
        notch[r] <= NOTCH_RST;
        for (int k = 0; k < ALPHA; k++) begin
          fwd[r][k] <= W'(k);
          bwd[r][k] <= W'(k);
        end
      end
      for (int k = 0; k < ALPHA; k++) begin
        refl[k] <= W'(k ^ 1);
      end
    end else begin
      cfg_err_q <= 1'b0;

      // Config and accept are mutually exclusive because cfg_we forces in_ready low.
      if (bus.cfg_we) begin
        if (cfg_bad) begin
          cfg_err_q <= 1'b1;
        end else begin
          for (int r = 0; r < NUM_ROTORS; r++) begin
            if (bus.cfg_sel == 3'(r)) begin
              case (bus.cfg_kind)
                2'd0: begin
                  fwd[r][bus.cfg_addr] <= bus.cfg_data;
                  bwd[r][bus.cfg_data] <= bus.cfg_addr;
                end
                2'd1:    pos[r]   <= bus.cfg_data;
                2'd2:    ring[r]  <= bus.cfg_data;
                default: notch[r] <= bus.cfg_data;
              endcase
            end
          end
          if (bus.cfg_kind == 2'd0 && {1'b0, bus.cfg_sel} == NR) begin
            refl[bus.cfg_addr] <= bus.cfg_data;
          end
        end
      end

      if (accept) begin
        out_valid_q <= 1'b1;
        if (in_range) begin
          out_char_q <= enc;
          out_err_q  <= 1'b0;
          step_q     <= step;
          for (int r = 0; r < NUM_ROTORS; r++) begin
            pos[r] <= q[r];
          end
        end else begin
          out_char_q <= bus.in_char;
          out_err_q  <= 1'b1;
          step_q     <= '0;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_char  = out_char_q;
  assign bus.out_err   = out_err_q;
  assign bus.step_vec  = step_q;
  assign bus.pos_out   = pos_flat;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_rotor_bank.sv
// Directed bench for rotor_bank (3 rotors, 26 letters); a second instance with
// DOUBLE_STEP=0 mirrors all stimulus and is compared only in the stepping test.
module tb_rotor_bank;
  logic clk;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  rotor_bank_if #(.NUM_ROTORS(3), .ALPHA(26)) ia ();
  rotor_bank_if #(.NUM_ROTORS(3), .ALPHA(26)) ib ();

  rotor_bank #(.NUM_ROTORS(3), .ALPHA(26), .DOUBLE_STEP(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  rotor_bank #(.NUM_ROTORS(3), .ALPHA(26), .DOUBLE_STEP(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  assign ib.cfg_we    = ia.cfg_we;
  assign ib.cfg_kind  = ia.cfg_kind;
  assign ib.cfg_sel   = ia.cfg_sel;
  assign ib.cfg_addr  = ia.cfg_addr;
  assign ib.cfg_data  = ia.cfg_data;
  assign ib.in_valid  = ia.in_valid;
  assign ib.in_char   = ia.in_char;
  assign ib.out_ready = ia.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int kind, input int sel, input int addr, input int data);
    ia.cfg_we   = 1'b1;
    ia.cfg_kind = 2'(kind);
    ia.cfg_sel  = 3'(sel);
    ia.cfg_addr = 5'(addr);
    ia.cfg_data = 5'(data);
    tick();
    ia.cfg_we   = 1'b0;
  endtask

  task automatic accept(input int ch);
    ia.in_valid = 1'b1;
    ia.in_char  = 5'(ch);
    tick();
    ia.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    ia.cfg_we    = 1'b0;
    ia.cfg_kind  = '0;
    ia.cfg_sel   = '0;
    ia.cfg_addr  = '0;
    ia.cfg_data  = '0;
    ia.in_valid  = 1'b0;
    ia.in_char   = '0;
    ia.out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", 32'(ia.out_valid), 0);
    check("rst_out_char",  32'(ia.out_char),  0);
    check("rst_out_err",   32'(ia.out_err),   0);
    check("rst_step_vec",  32'(ia.step_vec),  0);
    check("rst_cfg_err",   32'(ia.cfg_err),   0);
    check("rst_pos_out",   32'(ia.pos_out),   0);
    check("rst_in_ready",  32'(ia.in_ready),  1);

    // Identity rotors, reflector k^1: 0 -> 1, only rotor 0 steps
    accept(0);
    check("t1_out_valid", 32'(ia.out_valid), 1);
    check("t1_out_char",  32'(ia.out_char),  1);
    check("t1_step_vec",  32'(ia.step_vec),  32'b001);
    check("t1_pos_out",   32'(ia.pos_out),   1);
    check("t1_out_err",   32'(ia.out_err),   0);
    tick();
    check("t1_out_valid_clr", 32'(ia.out_valid), 0);

    // Rotor 0 as a +1 shift: overall map is refl(x+1)-1
    for (int k = 0; k < 26; k++) cfg(0, 0, k, (k + 1) % 26);
    check("t2_cfg_err", 32'(ia.cfg_err), 0);
    cfg(1, 0, 0, 0);
    accept(0);
    check("t2_out_char_0", 32'(ia.out_char), 25);
    check("t2_pos_out",    32'(ia.pos_out),  1);

    // Config and input in the same cycle: config wins, no accept
    ia.in_valid = 1'b1;
    ia.in_char  = 5'd25;
    ia.cfg_we   = 1'b1;
    ia.cfg_kind = 2'd1;
    ia.cfg_sel  = 3'd0;
    ia.cfg_addr = 5'd0;
    ia.cfg_data = 5'd0;
    #1;
    check("t2_in_ready_cfg", 32'(ia.in_ready), 0);
    tick();
    check("t2_no_accept", 32'(ia.out_valid), 0);
    check("t2_pos_cfg",   32'(ia.pos_out),   0);
    ia.cfg_we = 1'b0;
    tick();
    ia.in_valid = 1'b0;
    check("t2_accept_valid", 32'(ia.out_valid), 1);
    check("t2_out_char_25",  32'(ia.out_char),  0);
    check("t2_pos_after",    32'(ia.pos_out),   1);

    // Notch carry: pos0 3 -> 4 carries into rotor 1
    cfg(3, 0, 0, 3);
    cfg(1, 0, 0, 3);
    accept(0);
    check("t3_pos_carry", 32'(ia.pos_out),  4 + (1 << 5));
    check("t3_step_vec",  32'(ia.step_vec), 32'b011);
    // Wrap 25 -> 0
    cfg(1, 0, 0, 25);
    accept(0);
    check("t3_pos_wrap",  32'(ia.pos_out),  (1 << 5));
    check("t3_step_wrap", 32'(ia.step_vec), 32'b001);
    check("t3_out_char",  32'(ia.out_char), 25);

    // Double step: notch1=5, pos {10,5,0}
    cfg(3, 1, 0, 5);
    cfg(1, 0, 0, 10);
    cfg(1, 1, 0, 5);
    cfg(1, 2, 0, 0);
    accept(0);
    check("t4_dbl_pos",  32'(ia.pos_out),  11 + (6 << 5) + (1 << 10));
    check("t4_dbl_step", 32'(ia.step_vec), 32'b111);
    // Without double step rotor 1 holds; rotor 2 still steps since rotor 1 sits on its notch
    check("t4_odo_pos",  32'(ib.pos_out),  11 + (5 << 5) + (1 << 10));
    check("t4_odo_step", 32'(ib.step_vec), 32'b101);

    // Backpressure
    cfg(1, 0, 0, 0);
    cfg(1, 1, 0, 0);
    cfg(1, 2, 0, 0);
    ia.out_ready = 1'b0;
    ia.in_valid  = 1'b1;
    ia.in_char   = 5'd0;
    tick();
    check("t5_first_valid", 32'(ia.out_valid), 1);
    check("t5_first_char",  32'(ia.out_char),  25);
    ia.in_char = 5'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_bp_in_ready", 32'(ia.in_ready), 0);
      tick();
      check("t5_bp_valid", 32'(ia.out_valid), 1);
      check("t5_bp_char",  32'(ia.out_char),  25);
      check("t5_bp_pos",   32'(ia.pos_out),   1);
    end
    ia.out_ready = 1'b1;
    #1;
    check("t5_release_rdy", 32'(ia.in_ready), 1);
    tick();
    check("t5_acc1_char", 32'(ia.out_char), 8);
    check("t5_acc1_pos",  32'(ia.pos_out),  2);
    tick();
    check("t5_acc2_char", 32'(ia.out_char), 8);
    check("t5_acc2_pos",  32'(ia.pos_out),  3);
    tick();
    check("t5_acc3_char", 32'(ia.out_char), 8);
    check("t5_acc3_pos",  32'(ia.pos_out),  4 + (1 << 5));
    check("t5_acc3_step", 32'(ia.step_vec), 32'b011);
    ia.in_valid = 1'b0;
    tick();
    check("t5_drain", 32'(ia.out_valid), 0);

    // Reflector write refl[8]=20: 7 -> refl(8)-1 = 19
    cfg(0, 3, 8, 20);
    accept(7);
    check("t6_refl_char", 32'(ia.out_char), 19);
    check("t6_refl_pos",  32'(ia.pos_out),  5 + (1 << 5));

    // Dropped writes
    cfg(0, 3, 8, 26);
    check("t7_err_data", 32'(ia.cfg_err), 1);
    tick();
    check("t7_err_pulse", 32'(ia.cfg_err), 0);
    cfg(1, 3, 0, 4);
    check("t7_err_sel", 32'(ia.cfg_err), 1);
    cfg(0, 0, 26, 0);
    check("t7_err_addr", 32'(ia.cfg_err), 1);
    accept(7);
    check("t7_unchanged_char", 32'(ia.out_char), 19);
    check("t7_unchanged_pos",  32'(ia.pos_out),  6 + (1 << 5));

    // Out-of-range passthrough
    accept(30);
    check("t8_oor_char", 32'(ia.out_char), 30);
    check("t8_oor_err",  32'(ia.out_err),  1);
    check("t8_oor_step", 32'(ia.step_vec), 0);
    check("t8_oor_pos",  32'(ia.pos_out),  6 + (1 << 5));
    accept(0);
    check("t8_next_err",  32'(ia.out_err),  0);
    check("t8_next_char", 32'(ia.out_char), 25);
    check("t8_next_pos",  32'(ia.pos_out),  7 + (1 << 5));

    // Reset while holding an output
    ia.out_ready = 1'b0;
    accept(1);
    check("t9_held_valid", 32'(ia.out_valid), 1);
    reset = 1'b1;
    tick();
    check("t9_rst_valid", 32'(ia.out_valid), 0);
    check("t9_rst_pos",   32'(ia.pos_out),   0);
    reset = 1'b0;
    ia.out_ready = 1'b1;
    tick();
    check("t9_post_valid", 32'(ia.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
